// File: rtl/cmd_dispatch.sv
// rtl/cmd_dispatch.sv - command sequencer between the UART link and the flight controller
// Applies setpoint/calibration commands, answers ACK/NAK, and zeroes setpoints on watchdog expiry.
module cmd_dispatch #(
    parameter int         WDOG_W = 26,
    parameter logic [7:0] ACK    = 8'hA5,
    parameter logic [7:0] NAK    = 8'hEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        clr_cmd_rdy,
    output logic [7:0]  resp,
    output logic        send_resp,
    input  logic        resp_sent,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        motors_off
);

    localparam logic [7:0] CMD_PTCH  = 8'h02;
    localparam logic [7:0] CMD_ROLL  = 8'h03;
    localparam logic [7:0] CMD_YAW   = 8'h04;
    localparam logic [7:0] CMD_THRST = 8'h05;
    localparam logic [7:0] CMD_CAL   = 8'h06;
    localparam logic [7:0] CMD_LAND  = 8'h07;
    localparam logic [7:0] CMD_OFF   = 8'h08;

    typedef enum logic [2:0] {IDLE, EXEC, CAL_WAIT, RESP, RESP_WAIT} state_t;

    state_t              state, state_nxt;
    logic                clr_nxt, strt_nxt, send_nxt;
    logic [7:0]          cmd_q;
    logic [15:0]         data_q;
    logic [WDOG_W-1:0]   wdog;
    logic                wdog_sat;
    logic                accept;
    logic                known_cmd;

    assign accept    = (state == IDLE) && cmd_rdy;
    assign wdog_sat  = &wdog;
    assign known_cmd = (cmd_q >= CMD_PTCH) && (cmd_q <= CMD_OFF);

    always_comb begin
        state_nxt = state;
        clr_nxt   = 1'b0;
        strt_nxt  = 1'b0;
        send_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_rdy) begin
                    clr_nxt   = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cmd_q == CMD_CAL) begin
                    strt_nxt  = 1'b1;
                    state_nxt = CAL_WAIT;
                end else begin
                    state_nxt = RESP;
                end
            end
            CAL_WAIT: begin
                if (cal_done) state_nxt = RESP;
            end
            RESP: begin
                send_nxt  = 1'b1;
                state_nxt = RESP_WAIT;
            end
            RESP_WAIT: begin
                if (resp_sent) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            clr_cmd_rdy <= 1'b0;
            strt_cal    <= 1'b0;
            send_resp   <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_cmd_rdy <= clr_nxt;
            strt_cal    <= strt_nxt;
            send_resp   <= send_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= 8'h00;
            data_q     <= 16'h0000;
            wdog       <= '0;
            resp       <= 8'h00;
            d_ptch     <= 16'h0000;
            d_roll     <= 16'h0000;
            d_yaw      <= 16'h0000;
            thrst      <= 9'h000;
            motors_off <= 1'b1;
        end else begin
            if (accept) begin
                cmd_q  <= cmd;
                data_q <= data;
                wdog   <= '0;
            end else if (!wdog_sat) begin
                wdog <= wdog + WDOG_W'(1);
            end

            // Acceptance on the expiry cycle suppresses the forced landing.
            if (wdog_sat && !accept) begin
                d_ptch <= 16'h0000;
                d_roll <= 16'h0000;
                d_yaw  <= 16'h0000;
                thrst  <= 9'h000;
            end

            if (state == EXEC) begin
                case (cmd_q)
                    CMD_PTCH:  d_ptch <= data_q;
                    CMD_ROLL:  d_roll <= data_q;
                    CMD_YAW:   d_yaw  <= data_q;
                    CMD_THRST: thrst  <= data_q[8:0];
                    CMD_CAL:   motors_off <= 1'b0;
                    CMD_LAND: begin
                        d_ptch <= 16'h0000;
                        d_roll <= 16'h0000;
                        d_yaw  <= 16'h0000;
                        thrst  <= 9'h000;
                    end
                    CMD_OFF:   motors_off <= 1'b1;
                    default: ;
                endcase
            end

            if (state == RESP) resp <= known_cmd ? ACK : NAK;
        end
    end

endmodule
